// File: rtl/ofs_plat_prim_lutram_counter_pkg.sv
// Shared types and helpers for the LUTRAM counter arbiter and its interface.
// Latency: n/a (declarations only); backpressure: n/a.
package ofs_plat_prim_lutram_counter_pkg;

  typedef enum logic {CTR_INIT, CTR_RUN} t_ctr_state;

  // Widest counter the add helper supports; callers zero-extend into it.
  localparam int CTR_MAX_BITS = 64;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Add two width-bit values held in CTR_MAX_BITS containers; on carry out of
  // bit width-1 either clamp to all-ones (sat) or keep the wrapped low bits.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_add(
    input logic [CTR_MAX_BITS-1:0] a,
    input logic [CTR_MAX_BITS-1:0] b,
    input int width,
    input logic sat
  );
    logic [CTR_MAX_BITS:0]   sum;
    logic [CTR_MAX_BITS-1:0] mask;
    sum  = {1'b0, a} + {1'b0, b};
    mask = (64'd1 << width) - 64'd1;
    if (sat && ((sum >> width) != '0)) begin
      return mask;
    end
    return sum[CTR_MAX_BITS-1:0] & mask;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_lutram_counter_arb_if.sv
// Request/response bundle between requesters (master) and the counter table (slave).
// Latency: wires only; backpressure: one-hot req_ready grant, responses are never stalled.
interface ofs_plat_prim_lutram_counter_arb_if
  import ofs_plat_prim_lutram_counter_pkg::*;
#(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 16,
  parameter int N_REQ       = 4
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int IW = idx_bits(N_REQ);

  logic                                rdy;
  logic                                clear;
  logic [N_REQ-1:0]                    req_valid;
  logic [N_REQ-1:0]                    req_ready;
  logic [N_REQ-1:0][AW-1:0]            req_addr;
  logic [N_REQ-1:0][N_DATA_BITS-1:0]   req_delta;
  logic                                rsp_valid;
  logic [IW-1:0]                       rsp_idx;
  logic [N_DATA_BITS-1:0]              rsp_value;

  modport master (
    input  rdy, req_ready, rsp_valid, rsp_idx, rsp_value,
    output clear, req_valid, req_addr, req_delta
  );

  modport slave (
    output rdy, req_ready, rsp_valid, rsp_idx, rsp_value,
    input  clear, req_valid, req_addr, req_delta
  );

endinterface

// File: rtl/ofs_plat_prim_lutram.sv
// Small LUT RAM: combinational read port, registered write port.
// Latency: read 0 cycles, write visible after the clock edge; backpressure: none.
module ofs_plat_prim_lutram #(
  parameter int    N_ENTRIES         = 32,
  parameter int    N_DATA_BITS       = 16,
  parameter string READ_DURING_WRITE = "DONT_CARE",
  localparam int   AW                = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic [AW-1:0]          raddr,
  output logic [N_DATA_BITS-1:0] rdata,
  input  logic                   wen,
  input  logic [AW-1:0]          waddr,
  input  logic [N_DATA_BITS-1:0] wdata
);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (READ_DURING_WRITE == "NEW_DATA") begin : g_new_data
      assign rdata = (wen && (raddr == waddr)) ? wdata : mem[raddr];
    end else begin : g_dont_care
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/ofs_plat_prim_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer advances past the winner on the next edge.
module ofs_plat_prim_rr_arb #(
  parameter int  N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_vld
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    ptr_d     = ptr_q;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((32'(ptr_q) + 32'(k)) % 32'(N_REQ));
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        ptr_d       = (32'(cand) == 32'(N_REQ - 1)) ? '0 : cand + 1'b1;
      end
    end
    grant_vld = found;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ofs_plat_prim_lutram_counter_arb.sv
// Shared LUTRAM counter table with round-robin read-modify-write and init/clear sequencing.
// Latency: response and table write 1 cycle after grant; backpressure: req_ready grant only, responses never stall.
module ofs_plat_prim_lutram_counter_arb
  import ofs_plat_prim_lutram_counter_pkg::*;
#(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 16,
  parameter int N_REQ       = 4,
  parameter int SATURATE    = 1
) (
  input  logic clk,
  input  logic reset,
  ofs_plat_prim_lutram_counter_arb_if.slave ctr
);

  localparam int AW = $clog2(N_ENTRIES);
  localparam int IW = idx_bits(N_REQ);

  typedef logic [AW-1:0]          t_addr;
  typedef logic [N_DATA_BITS-1:0] t_value;
  typedef logic [IW-1:0]          t_idx;

  typedef struct packed {
    t_addr  addr;
    t_value old_val;
    t_value delta;
    t_idx   idx;
  } t_s1;

  t_ctr_state state_q, state_d;
  t_addr      init_addr_q, init_addr_d;
  logic       s1_vld_q, s1_vld_d;
  t_s1        s1_q, s1_d;

  logic   arb_en;
  logic   gnt_vld;
  t_idx   gnt_idx;
  t_addr  rd_addr;
  t_value rd_data;
  t_value new_val;
  logic   fwd_hit;
  logic   wen;
  t_addr  waddr;
  t_value wdata;

  // No grants while initializing, in the clear cycle, or while reset is held.
  assign arb_en = (state_q == CTR_RUN) && !ctr.clear && !reset;

  ofs_plat_prim_rr_arb #(
    .N_REQ(N_REQ)
  ) arb (
    .clk       (clk),
    .reset     (reset),
    .en        (arb_en),
    .req       (ctr.req_valid),
    .grant     (ctr.req_ready),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  assign rd_addr = ctr.req_addr[gnt_idx];

  ofs_plat_prim_lutram #(
    .N_ENTRIES         (N_ENTRIES),
    .N_DATA_BITS       (N_DATA_BITS),
    .READ_DURING_WRITE ("DONT_CARE")
  ) table_mem (
    .clk   (clk),
    .raddr (rd_addr),
    .rdata (rd_data),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata)
  );

  assign new_val = N_DATA_BITS'(ctr_add(CTR_MAX_BITS'(s1_q.old_val), CTR_MAX_BITS'(s1_q.delta),
                                        N_DATA_BITS, SATURATE != 0));

  // The table write for stage 1 lands on the same edge stage 0 reads, so bypass it.
  assign fwd_hit = s1_vld_q && (s1_q.addr == rd_addr);

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    s1_vld_d    = 1'b0;
    s1_d        = s1_q;
    wen         = 1'b0;
    waddr       = s1_q.addr;
    wdata       = new_val;

    case (state_q)
      CTR_INIT: begin
        wen         = 1'b1;
        waddr       = init_addr_q;
        wdata       = '0;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == AW'(N_ENTRIES - 1)) begin
          state_d = CTR_RUN;
        end
      end
      CTR_RUN: begin
        wen = s1_vld_q;
        if (ctr.clear) begin
          state_d     = CTR_INIT;
          init_addr_d = '0;
        end
      end
      default: begin
        state_d = CTR_INIT;
      end
    endcase

    if (gnt_vld) begin
      s1_vld_d     = 1'b1;
      s1_d.addr    = rd_addr;
      s1_d.old_val = fwd_hit ? new_val : rd_data;
      s1_d.delta   = ctr.req_delta[gnt_idx];
      s1_d.idx     = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CTR_INIT;
      init_addr_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_q        <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_q        <= s1_d;
    end
  end

  assign ctr.rdy       = (state_q == CTR_RUN);
  assign ctr.rsp_valid = s1_vld_q && !reset;
  assign ctr.rsp_idx   = s1_q.idx;
  assign ctr.rsp_value = new_val;

endmodule

// File: doc/ofs_plat_prim_lutram_counter_arb.md
Name: ofs_plat_prim_lutram_counter_arb

Overview:
- Shared table of N_ENTRIES counters held in one ofs_plat_prim_lutram instance (READ_DURING_WRITE="DONT_CARE").
- N_REQ requesters submit read-modify-write increments. A round-robin scheduler grants one request per cycle and runs a 2-stage read/add/write pipeline with internal forwarding.
- The controller also sequences table initialization after reset and on a clear command.
- Used for per-tag/per-channel statistics and credit counters in platform shims.

Parameters:
- N_ENTRIES, 32, table depth; power of 2, >=2.
- N_DATA_BITS, 16, counter width.
- N_REQ, 4, number of requesters, >=1.
- SATURATE, 1, 1 = clamp sum at all-ones; 0 = wrap modulo 2^N_DATA_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rdy  out  1  high when table initialized and accepting requests.
- clear  in  1  pulse: re-zero whole table.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot grant; request consumed when valid&&ready.
- req_addr[0:N_REQ-1]  in  $clog2(N_ENTRIES) each  counter index.
- req_delta[0:N_REQ-1]  in  N_DATA_BITS each  increment; 0 = pure read.
- rsp_valid  out  1  response valid; no backpressure.
- rsp_idx  out  $clog2(N_REQ) (min 1)  requester that owns the response.
- rsp_value  out  N_DATA_BITS  counter value after update.

Behaviour:
- Reset values: rdy=0, req_ready=0, rsp_valid=0, rsp_idx=0, rsp_value=0. The stage-1 valid bit and the RR pointer (pointing at requester 0) are cleared. State goes to INIT with init address 0.
- FSM state INIT:
  - Each cycle, write 0 to init_addr and increment init_addr.
  - After writing address N_ENTRIES-1, go to RUN; rdy=1 from the next cycle.
  - INIT lasts exactly N_ENTRIES cycles. req_ready=0 throughout.
- FSM state RUN: rdy=1. On clear=1, go to INIT next cycle with init_addr=0, and grant nothing in that cycle. clear is ignored while in INIT.
- Arbitration (stage 0):
  - In RUN with clear=0, grant the first valid requester at or after the RR pointer, wrapping around.
  - req_ready is combinational from req_valid and the pointer, and is 0 when no request is valid.
  - After a grant to i, the pointer becomes (i+1) mod N_REQ. The pointer is unchanged when nothing is granted.
- Stage 0 read:
  - Issue a combinational lutram read of the granted addr.
  - If stage 1 is valid and holds the same addr, use stage 1's new value (forwarding) instead of the lutram output.
  - Register the old value, delta, addr and idx into stage 1.
- Stage 1 (1 cycle after grant):
  - sum = old + delta, computed at N_DATA_BITS+1 bits.
  - If SATURATE and the carry is set, result = all-ones; otherwise result = low bits.
  - Write the result to addr. Drive rsp_valid=1, rsp_idx, rsp_value=result combinationally from the stage-1 registers.
- Latency: grant at cycle t produces the response and the table write at cycle t+1. Throughput is one op per cycle, including back-to-back ops to the same address.
- Write-port sharing: only stage 1 writes in RUN, and only the init sequencer writes in INIT.
- Clear with an op in flight: the stage-1 op from the cycle before clear still writes and responds. The next cycle begins INIT, so there is no write-port conflict. Its value is then overwritten by INIT.
- Reset mid-operation:
  - The stage-1 op is dropped, with no response.
  - Table contents are undefined until INIT completes.
- delta=0 performs a write-back of the same value; this is harmless and returns the current value.

Decomposition:
- Shared package ofs_plat_prim_lutram_counter_pkg holds:
  - the state enum t_ctr_state {CTR_INIT, CTR_RUN};
  - a helper function for saturating/wrapping add, parameterized by width via a localparam-sized wrapper or inline.
- Address, value and index types are local typedefs derived from parameters.
- One natural sub-module: ofs_plat_prim_rr_arb, an N_REQ round-robin arbiter with a grant-enable input, a one-hot grant output and an encoded index output. It is reusable elsewhere.
- Storage is the existing ofs_plat_prim_lutram instance.

Test Plan:
- Reset, N_ENTRIES=32 -> rdy rises exactly 32 cycles after reset deasserts. Then delta=0 reads of addrs 0..31 all return 0.
- Requesters 0 and 2 hold valid continuously with addr=5 and delta=1, starting at cycle c -> grants alternate 0,2,0,2, one per cycle. Responses arrive the next cycle with rsp_value 1,2,3,4 and rsp_idx 0,2,0,2. This proves forwarding.
- SATURATE=1, N_DATA_BITS=8: addr 3 is set to 250, then delta=10 -> rsp_value=255. With SATURATE=0 the same stimulus gives rsp_value=4.
- All 4 requesters valid for 8 cycles, each on a distinct addr with delta=1 -> grant order 0,1,2,3,0,1,2,3. Each counter ends at 2. req_ready is one-hot every cycle.
- Counter addr 7 is at 9. clear is asserted in the same cycle that an op from the previous cycle (addr 7, delta=1) is in stage 1 -> response value 10 is produced. rdy drops next cycle and returns 32 cycles later. A read of addr 7 then returns 0.
- reset is asserted with an op in stage 1 -> no rsp_valid is produced. rdy=0 until INIT completes, and the RR pointer restarts at 0, so the first grant goes to requester 0 when all are valid.
